// File: rtl/cache_line_adapter.sv
// Line buffer between the L1 controller and main memory: assembles fill lines
// word-by-word and serializes dirty victim lines back to memory.
module cache_line_adapter #(
  parameter int unsigned WORDS  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      we_cl,
  input  logic                      next_cl,
  input  logic [1:0]                sel_cl,
  input  logic [ADDR_W-1:0]         addr_imem,
  input  logic [ADDR_W-1:0]         addr_dmem,
  input  logic [ADDR_W-1:0]         addr_victim,
  input  logic [DATA_W-1:0]         mm_rdata,
  input  logic [WORDS*DATA_W-1:0]   dmem_line,
  output logic                      full_cl,
  output logic [ADDR_W-1:0]         mm_addr,
  output logic [DATA_W-1:0]         mm_wdata,
  output logic [WORDS*DATA_W-1:0]   line_out
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned LB    = $clog2(WORDS * DATA_W / 8);
  localparam int unsigned IW    = $clog2(WORDS);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << LB;
  localparam logic [IW-1:0]     LAST_IDX   = IW'(WORDS - 1);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(BYTES);

  localparam logic [1:0] SEL_IMEM   = 2'b00;
  localparam logic [1:0] SEL_DMEM   = 2'b01;
  localparam logic [1:0] SEL_VICTIM = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_LOADED,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [ADDR_W-1:0]              base_q, base_d;
  logic [WORDS-1:0][DATA_W-1:0]   line_q, line_d;

  logic [ADDR_W-1:0]              sel_addr;
  logic [ADDR_W-1:0]              aligned_sel;
  logic [ADDR_W-1:0]              word_off;

  always_comb begin
    sel_addr = '0;
    case (sel_cl)
      SEL_IMEM:   sel_addr = addr_imem;
      SEL_DMEM:   sel_addr = addr_dmem;
      SEL_VICTIM: sel_addr = addr_victim;
      default:    sel_addr = '0;
    endcase
    aligned_sel = sel_addr & ALIGN_MASK;
    word_off    = ADDR_W'(idx_q) * WORD_BYTES;
  end

  // In IDLE the address tracks the live request so memory can start the
  // first beat in the same cycle as we_cl; afterwards it follows the latched base.
  assign mm_addr  = ((state_q == ST_IDLE) ? aligned_sel : base_q) + word_off;
  assign mm_wdata = line_q[idx_q];
  assign line_out = line_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    line_d  = line_q;
    full_cl = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (we_cl) begin
          if (sel_cl == SEL_IMEM || sel_cl == SEL_DMEM) begin
            base_d  = aligned_sel;
            state_d = ST_FILL;
            if (next_cl) begin
              line_d[0] = mm_rdata;
              idx_d     = IW'(1);
            end
          end else if (sel_cl == SEL_VICTIM) begin
            line_d  = dmem_line;
            base_d  = aligned_sel;
            idx_d   = '0;
            state_d = ST_LOADED;
          end
        end
      end

      ST_FILL: begin
        if (next_cl) begin
          line_d[idx_q] = mm_rdata;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      ST_LOADED: begin
        full_cl = 1'b1;
        state_d = ST_DRAIN;
      end

      ST_DRAIN: begin
        if (next_cl) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      ST_DONE: begin
        full_cl = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: tb/tb_cache_line_adapter.sv
// Directed self-checking bench for cache_line_adapter (WORDS=4, 32-bit data/address).
module tb_cache_line_adapter;

  localparam int unsigned WORDS  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  logic                    clk;
  logic                    reset;
  logic                    clr;
  logic                    we_cl;
  logic                    next_cl;
  logic [1:0]              sel_cl;
  logic [ADDR_W-1:0]       addr_imem;
  logic [ADDR_W-1:0]       addr_dmem;
  logic [ADDR_W-1:0]       addr_victim;
  logic [DATA_W-1:0]       mm_rdata;
  logic [WORDS*DATA_W-1:0] dmem_line;
  logic                    full_cl;
  logic [ADDR_W-1:0]       mm_addr;
  logic [DATA_W-1:0]       mm_wdata;
  logic [WORDS*DATA_W-1:0] line_out;

  int n_chk;
  int n_fail;

  cache_line_adapter #(
    .WORDS  (WORDS),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .we_cl       (we_cl),
    .next_cl     (next_cl),
    .sel_cl      (sel_cl),
    .addr_imem   (addr_imem),
    .addr_dmem   (addr_dmem),
    .addr_victim (addr_victim),
    .mm_rdata    (mm_rdata),
    .dmem_line   (dmem_line),
    .full_cl     (full_cl),
    .mm_addr     (mm_addr),
    .mm_wdata    (mm_wdata),
    .line_out    (line_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; clr = 1'b1; we_cl = 1'b1; next_cl = 1'b1; sel_cl = 2'b11;
    addr_imem = '1; addr_dmem = '1; addr_victim = '1; mm_rdata = '1; dmem_line = '1;
    tick();
    tick();
    #1;
    n_chk++; if (full_cl !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full_cl); end
    n_chk++; if (line_out !== '0) begin n_fail++; $display("FAIL reset_line: got %h expected 0", line_out); end
    n_chk++; if (mm_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mm_addr); end
    n_chk++; if (mm_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mm_wdata); end
    reset = 1'b1; clr = 1'b0; we_cl = 1'b0; next_cl = 1'b0; sel_cl = 2'b00;
    addr_imem = '0; addr_dmem = '0; addr_victim = '0; mm_rdata = '0; dmem_line = '0;
    tick();
  endtask

  task automatic test_ifill();
    logic [31:0] data [4];
    logic [31:0] eaddr [4];
    data  = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    eaddr = '{32'h0000_1230, 32'h0000_1234, 32'h0000_1238, 32'h0000_123C};
    addr_imem = 32'h0000_1234; sel_cl = 2'b00; we_cl = 1'b1; next_cl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mm_rdata = data[i];
      #1;
      n_chk++; if (mm_addr !== eaddr[i]) begin n_fail++; $display("FAIL ifill_addr[%0d]: got %h expected %h", i, mm_addr, eaddr[i]); end
      n_chk++; if (full_cl !== 1'b0) begin n_fail++; $display("FAIL ifill_full_early[%0d]: got %b expected 0", i, full_cl); end
      tick();
    end
    we_cl = 1'b0; next_cl = 1'b0; mm_rdata = 32'hDEAD_BEEF;
    #1;
    n_chk++; if (full_cl !== 1'b1) begin n_fail++; $display("FAIL ifill_full: got %b expected 1", full_cl); end
    n_chk++; if (line_out !== 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001) begin
      n_fail++; $display("FAIL ifill_line: got %h expected DDDD0004CCCC0003BBBB0002AAAA0001", line_out); end
    tick();
    #1;
    n_chk++; if (full_cl !== 1'b0) begin n_fail++; $display("FAIL ifill_full_after: got %b expected 0", full_cl); end
    n_chk++; if (line_out !== 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001) begin
      n_fail++; $display("FAIL ifill_line_hold: got %h", line_out); end
  endtask

  task automatic test_dfill_stall();
    logic        pat [7];
    logic [31:0] eaddr [7];
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    eaddr = '{32'h40, 32'h44, 32'h44, 32'h44, 32'h48, 32'h4C, 32'h4C};
    addr_dmem = 32'h0000_0040; addr_imem = 32'h0000_9000; sel_cl = 2'b01;
    for (int i = 0; i < 7; i++) begin
      we_cl    = (i == 0) || (i % 2 == 1);
      next_cl  = pat[i];
      mm_rdata = 32'hD000_0000 + 32'(i);
      if (i > 0) sel_cl = (i % 2 == 1) ? 2'b00 : 2'b10;
      #1;
      n_chk++; if (mm_addr !== eaddr[i]) begin n_fail++; $display("FAIL dfill_addr[%0d]: got %h expected %h", i, mm_addr, eaddr[i]); end
      n_chk++; if (full_cl !== 1'b0) begin n_fail++; $display("FAIL dfill_full_early[%0d]: got %b expected 0", i, full_cl); end
      tick();
    end
    we_cl = 1'b0; next_cl = 1'b0; sel_cl = 2'b01;
    #1;
    n_chk++; if (full_cl !== 1'b1) begin n_fail++; $display("FAIL dfill_full: got %b expected 1", full_cl); end
    n_chk++; if (line_out !== 128'hD000_0006_D000_0004_D000_0003_D000_0000) begin
      n_fail++; $display("FAIL dfill_line: got %h expected D0000006D0000004D0000003D0000000", line_out); end
    tick();
    #1;
    n_chk++; if (full_cl !== 1'b0) begin n_fail++; $display("FAIL dfill_single_pulse: got %b expected 0", full_cl); end
  endtask

  task automatic test_writeback(input bit poke_ignored);
    logic [31:0] wd [4];
    logic [31:0] eaddr [4];
    wd    = '{32'h1111_0000, 32'h2222_1111, 32'h3333_2222, 32'h4444_3333};
    eaddr = '{32'h8010, 32'h8014, 32'h8018, 32'h801C};
    addr_victim = 32'h0000_8014; sel_cl = 2'b10; we_cl = 1'b1; next_cl = 1'b1;
    dmem_line = {wd[3], wd[2], wd[1], wd[0]};
    #1;
    n_chk++; if (mm_addr !== 32'h8010) begin n_fail++; $display("FAIL wb_idle_addr: got %h expected 00008010", mm_addr); end
    tick();
    we_cl = 1'b0; dmem_line = '1;
    #1;
    n_chk++; if (full_cl !== 1'b1) begin n_fail++; $display("FAIL wb_load_full: got %b expected 1", full_cl); end
    n_chk++; if (line_out !== {wd[3], wd[2], wd[1], wd[0]}) begin n_fail++; $display("FAIL wb_line: got %h", line_out); end
    tick();
    for (int i = 0; i < 4; i++) begin
      if (poke_ignored) begin
        // stall once per word and flip the request to show DRAIN ignores it
        next_cl = 1'b0; we_cl = 1'b1; sel_cl = 2'b00; addr_imem = 32'h0000_5000;
        #1;
        n_chk++; if (mm_addr !== eaddr[i]) begin n_fail++; $display("FAIL ign_stall_addr[%0d]: got %h expected %h", i, mm_addr, eaddr[i]); end
        tick();
        we_cl = 1'b0;
      end
      next_cl = 1'b1;
      #1;
      n_chk++; if (mm_addr !== eaddr[i]) begin n_fail++; $display("FAIL wb_addr[%0d]: got %h expected %h", i, mm_addr, eaddr[i]); end
      n_chk++; if (mm_wdata !== wd[i]) begin n_fail++; $display("FAIL wb_wdata[%0d]: got %h expected %h", i, mm_wdata, wd[i]); end
      n_chk++; if (full_cl !== 1'b0) begin n_fail++; $display("FAIL wb_full_drain[%0d]: got %b expected 0", i, full_cl); end
      tick();
    end
    next_cl = 1'b0; we_cl = 1'b0; sel_cl = 2'b11;
    #1;
    n_chk++; if (full_cl !== 1'b1) begin n_fail++; $display("FAIL wb_done_full: got %b expected 1", full_cl); end
    tick();
    #1;
    n_chk++; if (full_cl !== 1'b0) begin n_fail++; $display("FAIL wb_idle_full: got %b expected 0", full_cl); end
    n_chk++; if (mm_addr !== 32'h0) begin n_fail++; $display("FAIL wb_idle_addr_after: got %h expected 0", mm_addr); end
  endtask

  task automatic test_illegal();
    logic [127:0] held;
    held = line_out;
    sel_cl = 2'b11; we_cl = 1'b1; next_cl = 1'b1; mm_rdata = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_chk++; if (full_cl !== 1'b0) begin n_fail++; $display("FAIL illegal_full[%0d]: got %b expected 0", i, full_cl); end
      n_chk++; if (mm_addr !== 32'h0) begin n_fail++; $display("FAIL illegal_addr[%0d]: got %h expected 0", i, mm_addr); end
    end
    n_chk++; if (line_out !== held) begin n_fail++; $display("FAIL illegal_line: got %h expected %h", line_out, held); end
    we_cl = 1'b0; next_cl = 1'b0;
    test_writeback(1'b1);
  endtask

  task automatic test_clear();
    addr_imem = 32'h0000_2000; sel_cl = 2'b00; we_cl = 1'b1; next_cl = 1'b1;
    mm_rdata = 32'hC1C1_C1C1;
    tick();
    we_cl = 1'b0; mm_rdata = 32'hC2C2_C2C2;
    tick();
    #1;
    n_chk++; if (mm_addr !== 32'h2008) begin n_fail++; $display("FAIL clr_pre_addr: got %h expected 00002008", mm_addr); end
    clr = 1'b1; next_cl = 1'b1;
    tick();
    clr = 1'b0; next_cl = 1'b0; addr_imem = 32'h0000_3004;
    #1;
    n_chk++; if (line_out !== '0) begin n_fail++; $display("FAIL clr_line: got %h expected 0", line_out); end
    n_chk++; if (mm_addr !== 32'h3000) begin n_fail++; $display("FAIL clr_idle_addr: got %h expected 00003000", mm_addr); end
    n_chk++; if (full_cl !== 1'b0) begin n_fail++; $display("FAIL clr_full: got %b expected 0", full_cl); end
    next_cl = 1'b1; mm_rdata = 32'hBAD0_BAD0;
    tick();
    next_cl = 1'b0;
    #1;
    n_chk++; if (line_out !== '0) begin n_fail++; $display("FAIL clr_no_capture: got %h expected 0", line_out); end
  endtask

  task automatic test_wrap();
    logic [31:0] eaddr [4];
    eaddr = '{32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    addr_imem = 32'hFFFF_FFF8; sel_cl = 2'b00; we_cl = 1'b1; next_cl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mm_rdata = 32'hE000_0000 + 32'(i);
      #1;
      n_chk++; if (mm_addr !== eaddr[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, mm_addr, eaddr[i]); end
      tick();
    end
    we_cl = 1'b0; next_cl = 1'b0;
    #1;
    n_chk++; if (full_cl !== 1'b1) begin n_fail++; $display("FAIL wrap_full: got %b expected 1", full_cl); end
    n_chk++; if (line_out !== 128'hE000_0003_E000_0002_E000_0001_E000_0000) begin
      n_fail++; $display("FAIL wrap_line: got %h", line_out); end
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0; clr = 1'b0; we_cl = 1'b0; next_cl = 1'b0; sel_cl = 2'b00;
    addr_imem = '0; addr_dmem = '0; addr_victim = '0; mm_rdata = '0; dmem_line = '0;
    tick();
    test_reset();
    test_ifill();
    test_dfill_stall();
    test_writeback(1'b0);
    test_illegal();
    test_clear();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_line_adapter.md
Name: cache_line_adapter

Overview:
- Line buffer between the L1 cache controller and main memory.
- Fill direction (I-miss or D-miss): assembles WORDS words from main memory into one cache line, then presents it to imem/dmem.
- Writeback direction (dirty D-victim): loads a whole dmem line in parallel, then serializes it word-by-word to main memory.
- Driven by the controller's clr, we_cl, next_cl and sel_cl; returns the full_cl handshake and drives main-memory address and write data.

Parameters:
WORDS, 4, words per cache line (power of 2, >=2)
DATA_W, 32, bits per word
ADDR_W, 32, byte-address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
clr  in  1  synchronous clear from controller
we_cl  in  1  controller requests a line transfer
next_cl  in  1  advance one word (main-memory word valid or word accepted)
sel_cl  in  2  transfer source: 00 mm->imem, 01 mm->dmem, 10 dmem->mm, 11 illegal
addr_imem  in  ADDR_W  I-miss byte address
addr_dmem  in  ADDR_W  D-miss byte address
addr_victim  in  ADDR_W  dirty victim line byte address
mm_rdata  in  DATA_W  read word from main memory
dmem_line  in  WORDS*DATA_W  victim line data, word 0 in LSBs
full_cl  out  1  one-cycle transfer-complete pulse
mm_addr  out  ADDR_W  word byte address to main memory
mm_wdata  out  DATA_W  writeback word
line_out  out  WORDS*DATA_W  assembled line, word 0 in LSBs

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, idx=0, base=0, buffer=0. Resulting outputs: full_cl=0, mm_addr=0, mm_wdata=0, line_out=0. reset takes priority over clr.
- clr=1 (reset high): same effect as reset, from any state, including mid-transfer.
- Sizes:
  - LB = log2(WORDS*DATA_W/8) line-offset bits.
  - idx is log2(WORDS) bits.
  - Line alignment clears the low LB address bits.
- mm_addr:
  - In IDLE: aligned(selected address) + idx*(DATA_W/8), where the selected address is addr_imem for sel 00, addr_dmem for 01, addr_victim for 10; 0 for 11.
  - In all other states: base + idx*(DATA_W/8).
  - Arithmetic is modulo 2^ADDR_W.
- mm_wdata = buffer[idx] at all times. line_out = buffer at all times; it holds until the next load, clr or reset.
- States:
  - IDLE:
    - we_cl with sel 00 or 01: base <= aligned(selected address), go to FILL. If next_cl is also high in this cycle, buffer[0] <= mm_rdata and idx <= 1.
    - we_cl with sel 10: buffer <= dmem_line, base <= aligned(addr_victim), idx <= 0, go to LOADED.
    - sel 11, or we_cl=0: stay in IDLE, no change.
  - FILL:
    - next_cl: buffer[idx] <= mm_rdata, idx++.
    - Capture of word WORDS-1: idx <= 0, go to DONE.
    - next_cl=0: hold. we_cl and sel_cl are ignored.
  - LOADED: full_cl=1 for exactly this cycle; go to DRAIN unconditionally; next_cl is ignored.
  - DRAIN:
    - next_cl: idx++ (word buffer[idx] accepted by main memory).
    - Acceptance of word WORDS-1: idx <= 0, go to DONE.
    - next_cl=0: hold.
  - DONE: full_cl=1 for exactly this cycle; go to IDLE; all inputs except reset and clr are ignored.
- full_cl is 0 in IDLE, FILL and DRAIN.
- Latencies:
  - A fill with next_cl high every cycle from the request cycle gives its full_cl pulse WORDS cycles after the request cycle.
  - A writeback gives a pulse 1 cycle after the load.
  - A drain gives a pulse 1 cycle after the last accepted word.
- Never captures or advances more than one word per cycle. idx never wraps outside DONE or reset/clr.

Test Plan:
- Reset and clear: hold reset=0 for 2 cycles with all inputs high -> full_cl=0, line_out=0, mm_addr=0. Repeat the check with clr=1 asserted in FILL after 2 words -> IDLE, idx=0, line_out=0.
- I-fill:
  - Stimulus: WORDS=4, addr_imem=0x0000_1234, sel 00, we_cl and next_cl high from cycle 0, mm_rdata=A,B,C,D.
  - mm_addr: 0x1230, 0x1234, 0x1238, 0x123C.
  - full_cl=1 only in cycle 4; line_out={D,C,B,A}.
- D-fill with stalls: sel 01, addr_dmem=0x40, next_cl pattern 1,0,0,1,1,0,1 -> mm_addr advances only after next_cl cycles, full_cl is a single pulse after the 4th word, and words land in order.
- Writeback:
  - Stimulus: sel 10, addr_victim=0x8014, dmem_line={W3,W2,W1,W0}.
  - full_cl pulses in the cycle after the load.
  - In DRAIN, with next_cl high: mm_addr=0x8010, 0x8014, 0x8018, 0x801C; mm_wdata=W0, W1, W2, W3.
  - Second full_cl pulse follows the last word; then IDLE.
- Illegal and ignored inputs: we_cl with sel 11 -> stays IDLE, no full_cl. we_cl toggling during FILL or DRAIN -> no effect on base or idx.
- Wrap: addr_imem=0xFFFF_FFF8 -> mm_addr=0xFFFF_FFF0, then 0xFFFF_FFF4, 0xFFFF_FFF8, 0xFFFF_FFFC, with no overflow artefacts.
